// File: rtl/seq_arith_4x1b_ser_gen.sv
// Bit-serial operand generator: parallel val/rdy pairs in, LSB-first
// serial A/B bits out in free-running NBITS-cycle frames.
module seq_arith_4x1b_ser_gen #(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_a,
    input  logic [NBITS-1:0] in_b,
    output logic             out0,
    output logic             out1,
    output logic             out_first,
    output logic             out_last,
    output logic             out_active
);

    localparam int CW = $clog2(NBITS);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    logic [CW-1:0]    cnt;
    logic [NBITS-1:0] sh_a;
    logic [NBITS-1:0] sh_b;
    logic [NBITS-1:0] buf_a;
    logic [NBITS-1:0] buf_b;
    logic             buf_full;
    logic             act;
    logic             xfer;
    logic             at_end;

    assign in_rdy = !buf_full && !reset;
    assign xfer   = in_val && in_rdy;
    assign at_end = (cnt == LAST);

    // Free-running frame-bit counter; never stalls so frames stay aligned
    // with the downstream adder's carry clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // One-entry pending buffer; drained at every frame boundary, either
    // into the shifters or bypassed because it was already empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_a    <= '0;
            buf_b    <= '0;
        end else if (at_end) begin
            buf_full <= 1'b0;
        end else if (xfer) begin
            buf_full <= 1'b1;
            buf_a    <= in_a;
            buf_b    <= in_b;
        end
    end

    // Shift out mid-frame; reload at the boundary from buffer, bypass or idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_a <= '0;
            sh_b <= '0;
            act  <= 1'b0;
        end else if (!at_end) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
        end else if (buf_full) begin
            sh_a <= buf_a;
            sh_b <= buf_b;
            act  <= 1'b1;
        end else if (xfer) begin
            sh_a <= in_a;
            sh_b <= in_b;
            act  <= 1'b1;
        end else begin
            sh_a <= '0;
            sh_b <= '0;
            act  <= 1'b0;
        end
    end

    assign out0       = sh_a[0];
    assign out1       = sh_b[0];
    assign out_first  = (cnt == '0);
    assign out_last   = at_end;
    assign out_active = act;

endmodule

// File: tb/tb_seq_arith_4x1b_ser_gen.sv
// Bench for seq_arith_4x1b_ser_gen: vector table plus frame scoreboard,
// hand-written reset-abort and NBITS=8 sequences.
module tb_seq_arith_4x1b_ser_gen;

    localparam int N = 4;

    typedef struct {
        int         tc;
        logic [3:0] a;
        logic [3:0] b;
        int         val_c;
        int         acc_c;
        int         start_c;
    } vec_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        int         start;
    } frame_t;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out0, out1, out_first, out_last, out_active;

    logic       r8;
    logic       val8;
    logic       rdy8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       o0_8, o1_8, first8, last8, act8;

    vec_t   vecs[$];
    frame_t sb[$];
    int     total;
    int     bad;
    int     cyc;

    seq_arith_4x1b_ser_gen #(.NBITS(4)) dut (
        .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy),
        .in_a(in_a), .in_b(in_b), .out0(out0), .out1(out1),
        .out_first(out_first), .out_last(out_last), .out_active(out_active)
    );

    seq_arith_4x1b_ser_gen #(.NBITS(8)) dut8 (
        .clk(clk), .reset(r8), .in_val(val8), .in_rdy(rdy8),
        .in_a(a8), .in_b(b8), .out0(o0_8), .out1(o1_8),
        .out_first(first8), .out_last(last8), .out_active(act8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, got, want);
        end
    endtask

    task automatic add(input int tc, input logic [3:0] a, input logic [3:0] b,
                       input int v, input int acc, input int st);
        vec_t e;
        e.tc = tc; e.a = a; e.b = b;
        e.val_c = v; e.acc_c = acc; e.start_c = st;
        vecs.push_back(e);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        in_val = 1'b0;
        in_a   = '0;
        in_b   = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic run_cycles(input int tc, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            logic       v, er, e0, e1, ea;
            logic [3:0] ta, tb;
            frame_t     f;
            int         idx;
            cyc = c;
            v = 1'b0; er = 1'b1; ta = '0; tb = '0;
            foreach (vecs[i]) begin
                if (vecs[i].tc == tc) begin
                    if (c >= vecs[i].val_c && c <= vecs[i].acc_c) begin
                        v = 1'b1; ta = vecs[i].a; tb = vecs[i].b;
                    end
                    if (c == vecs[i].acc_c) begin
                        f.a = vecs[i].a; f.b = vecs[i].b;
                        f.start = vecs[i].start_c;
                        sb.push_back(f);
                    end
                    if (c > vecs[i].acc_c && c < vecs[i].start_c &&
                        (vecs[i].acc_c % N) != N - 1)
                        er = 1'b0;
                    if (c >= vecs[i].val_c && c < vecs[i].acc_c)
                        er = 1'b0;
                end
            end
            in_val = v; in_a = ta; in_b = tb;
            @(negedge clk);
            e0 = 1'b0; e1 = 1'b0; ea = 1'b0; idx = -1;
            if (sb.size() > 0 && sb[0].start <= c) begin
                logic [3:0] sa, sbb;
                idx = c - sb[0].start;
                sa  = sb[0].a >> idx;
                sbb = sb[0].b >> idx;
                e0 = sa[0]; e1 = sbb[0]; ea = 1'b1;
            end
            chk("in_rdy", in_rdy, er);
            chk("out0", out0, e0);
            chk("out1", out1, e1);
            chk("out_active", out_active, ea);
            chk("out_first", out_first, (c % N) == 0);
            chk("out_last", out_last, (c % N) == N - 1);
            if (idx == N - 1) void'(sb.pop_front());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_case();
        chk("sb_drained", sb.size() == 0, 1'b1);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        reset = 1'b1; in_val = 1'b0; in_a = '0; in_b = '0;
        r8 = 1'b1; val8 = 1'b0; a8 = '0; b8 = '0;

        add(2, 4'b1011, 4'b0100, 0, 0, 4);
        add(3, 4'b1111, 4'b0001, 3, 3, 4);
        add(4, 4'b1100, 4'b0011, 0, 0, 4);
        add(4, 4'b1101, 4'b0010, 1, 4, 8);
        add(4, 4'b0100, 4'b0100, 5, 8, 12);
        add(7, 4'b0110, 4'b1001, 2, 2, 4);
        add(8, 4'b1010, 4'b0101, 1, 1, 4);
        add(8, 4'b0111, 4'b1110, 7, 7, 8);
        add(50, 4'b1001, 4'b0110, 0, 0, 4);
        add(51, 4'b0011, 4'b1010, 0, 0, 4);

        @(posedge clk);
        #1;

        do_reset(); run_cycles(1, 12); end_case();
        do_reset(); run_cycles(2, 8);  end_case();
        do_reset(); run_cycles(3, 8);  end_case();
        do_reset(); run_cycles(4, 16); end_case();
        do_reset(); run_cycles(7, 8);  end_case();
        do_reset(); run_cycles(8, 12); end_case();

        // reset at cnt=2 with the buffer holding a pair
        do_reset();
        run_cycles(50, 2);
        cyc = 2;
        reset = 1'b1; in_val = 1'b0;
        @(negedge clk);
        chk("rst_rdy", in_rdy, 1'b0);
        for (int k = 3; k < 5; k++) begin
            @(posedge clk);
            #1;
            cyc = k;
            @(negedge clk);
            chk("rst_rdy", in_rdy, 1'b0);
            chk("rst_out0", out0, 1'b0);
            chk("rst_out1", out1, 1'b0);
            chk("rst_first", out_first, 1'b1);
            chk("rst_last", out_last, 1'b0);
            chk("rst_active", out_active, 1'b0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        run_cycles(51, 8);
        end_case();

        // NBITS=8 instance
        @(posedge clk);
        #1;
        r8 = 1'b0; val8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
        for (int c = 0; c < 16; c++) begin
            cyc = 100 + c;
            if (c > 0) begin
                val8 = 1'b0; a8 = '0; b8 = '0;
            end
            @(negedge clk);
            if (c == 0) chk("n8_rdy", rdy8, 1'b1);
            chk("n8_out0", o0_8, c >= 8);
            chk("n8_out1", o1_8, c == 8);
            chk("n8_active", act8, c >= 8);
            chk("n8_first", first8, (c % 8) == 0);
            chk("n8_last", last8, (c % 8) == 7);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
